// File: rtl/kws_argmax_classifier.sv
// kws_argmax_classifier
//
// Final decision stage of the keyword-spotting datapath. Captures one vector
// of NUM_CLASSES unsigned scores on data_valid, scans it one element per
// cycle for the best and second-best scores, then publishes the winning
// class, its score, the best-to-second margin and a keyword-detect flag.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   data_in      in   score vector, element k at [k*ACTIV_BITS +: ACTIV_BITS]
//   data_valid   in   vector present this cycle
//   threshold    in   minimum winning score for detect
//   min_margin   in   minimum (best - second) for detect
//   ready        out  high when a vector can be accepted (IDLE)
//   class_out    out  winning index
//   score_out    out  winning score
//   margin_out   out  best - second
//   result_valid out  one-cycle pulse, new result on outputs
//   detect       out  registered with the result, holds until next result
//   drop         out  one-cycle pulse: data_valid arrived while ready was low
module kws_argmax_classifier #(
  parameter int NUM_CLASSES = 64,
  parameter int ACTIV_BITS  = 16,
  parameter int CLASS_BITS  = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLASSES*ACTIV_BITS-1:0] data_in,
  input  logic                              data_valid,
  input  logic [ACTIV_BITS-1:0]             threshold,
  input  logic [ACTIV_BITS-1:0]             min_margin,
  output logic                              ready,
  output logic [CLASS_BITS-1:0]             class_out,
  output logic [ACTIV_BITS-1:0]             score_out,
  output logic [ACTIV_BITS-1:0]             margin_out,
  output logic                              result_valid,
  output logic                              detect,
  output logic                              drop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CLASS_BITS-1:0] LAST_IDX = CLASS_BITS'(NUM_CLASSES - 1);

  state_t                  state;
  logic [ACTIV_BITS-1:0]   scores [NUM_CLASSES];
  logic [ACTIV_BITS-1:0]   thr;
  logic [ACTIV_BITS-1:0]   mrg;
  logic [ACTIV_BITS-1:0]   best;
  logic [ACTIV_BITS-1:0]   second;
  logic [CLASS_BITS-1:0]   best_idx;
  logic [CLASS_BITS-1:0]   idx;

  logic [ACTIV_BITS-1:0]   elem;
  logic [ACTIV_BITS-1:0]   diff;

  assign ready = (state == IDLE);
  assign elem  = scores[idx];
  // best >= second always holds, so this never wraps.
  assign diff  = best - second;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      for (int i = 0; i < NUM_CLASSES; i++) scores[i] <= '0;
      thr          <= '0;
      mrg          <= '0;
      best         <= '0;
      second       <= '0;
      best_idx     <= '0;
      idx          <= '0;
      class_out    <= '0;
      score_out    <= '0;
      margin_out   <= '0;
      result_valid <= 1'b0;
      detect       <= 1'b0;
      drop         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      // Any vector offered while busy is discarded and flagged next cycle.
      drop         <= data_valid && (state != IDLE);

      case (state)
        IDLE: begin
          if (data_valid) begin
            for (int i = 0; i < NUM_CLASSES; i++)
              scores[i] <= data_in[i*ACTIV_BITS +: ACTIV_BITS];
            thr      <= threshold;
            mrg      <= min_margin;
            best     <= '0;
            second   <= '0;
            best_idx <= '0;
            idx      <= '0;
            state    <= SCAN;
          end
        end

        SCAN: begin
          // Strict compares: ties keep the lower index and the duplicate
          // value becomes the runner-up.
          if (elem > best) begin
            second   <= best;
            best     <= elem;
            best_idx <= idx;
          end else if (elem > second) begin
            second <= elem;
          end
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= DONE;
        end

        DONE: begin
          class_out    <= best_idx;
          score_out    <= best;
          margin_out   <= diff;
          detect       <= (best >= thr) && (diff >= mrg);
          result_valid <= 1'b1;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kws_argmax_classifier.sv
module tb_kws_argmax_classifier;

  localparam int NC = 4;
  localparam int AB = 16;
  localparam int CB = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NC*AB-1:0] data_in = '0;
  logic             data_valid = 1'b0;
  logic [AB-1:0]    threshold = '0;
  logic [AB-1:0]    min_margin = '0;
  logic             ready;
  logic [CB-1:0]    class_out;
  logic [AB-1:0]    score_out;
  logic [AB-1:0]    margin_out;
  logic             result_valid;
  logic             detect;
  logic             drop;

  int tests = 0;
  int failed = 0;
  int lat;
  int seen;

  kws_argmax_classifier #(
    .NUM_CLASSES(NC),
    .ACTIV_BITS (AB),
    .CLASS_BITS (CB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .threshold   (threshold),
    .min_margin  (min_margin),
    .ready       (ready),
    .class_out   (class_out),
    .score_out   (score_out),
    .margin_out  (margin_out),
    .result_valid(result_valid),
    .detect      (detect),
    .drop        (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; sample/drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*AB-1:0] pack(input int e0, e1, e2, e3);
    pack = {AB'(e3), AB'(e2), AB'(e1), AB'(e0)};
  endfunction

  // Present a vector for exactly one edge.
  task automatic send(input logic [NC*AB-1:0] v, input int th, input int mm);
    data_in    = v;
    threshold  = AB'(th);
    min_margin = AB'(mm);
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  // Count edges after capture until result_valid, bounded.
  task automatic wait_result(output int n);
    n = 0;
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_result(input string tag, input int cls, input int sc,
                            input int mg, input int det);
    chk({tag, "_class"},  32'(class_out),  32'(cls));
    chk({tag, "_score"},  32'(score_out),  32'(sc));
    chk({tag, "_margin"}, 32'(margin_out), 32'(mg));
    chk({tag, "_detect"}, 32'(detect),     32'(det));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_rv", 32'(result_valid), 0);
    chk_result("rst", 0, 0, 0, 0);
    chk("rst_drop", 32'(drop), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic vector
    send(pack(10, 50, 30, 20), 40, 15);
    chk("basic_ready_low", 32'(ready), 0);
    wait_result(lat);
    chk("basic_latency", 32'(lat), 5);
    chk_result("basic", 1, 50, 20, 1);
    chk("basic_ready_high", 32'(ready), 1);
    tick();
    chk("basic_rv_pulse", 32'(result_valid), 0);
    chk("basic_detect_hold", 32'(detect), 1);
    $display("[TB] basic: class=%0d score=%0d margin=%0d detect=%0d", class_out, score_out, margin_out, detect);

    // Tie
    send(pack(10, 50, 30, 50), 40, 1);
    wait_result(lat);
    chk("tie_latency", 32'(lat), 5);
    chk_result("tie", 1, 50, 0, 0);
    tick();
    $display("[TB] tie: class=%0d score=%0d margin=%0d detect=%0d", class_out, score_out, margin_out, detect);

    // All zeros
    send(pack(0, 0, 0, 0), 0, 0);
    wait_result(lat);
    chk("zero_latency", 32'(lat), 5);
    chk_result("zero", 0, 0, 0, 1);
    tick();
    send(pack(0, 0, 0, 0), 1, 0);
    wait_result(lat);
    chk_result("zero_th1", 0, 0, 0, 0);
    tick();
    $display("[TB] zeros: th0 detect=1 expected, th1 detect=%0d", detect);

    // Drop while busy, then back-to-back accept in the result cycle
    send(pack(10, 50, 30, 20), 40, 15);      // E0
    tick();                                   // E1
    data_in    = pack(0, 0, 0, 7);
    threshold  = '0;
    min_margin = '0;
    data_valid = 1'b1;
    tick();                                   // E2: ignored
    data_valid = 1'b0;
    chk("drop_pulse", 32'(drop), 1);
    chk("drop_ready", 32'(ready), 0);
    tick();                                   // E3
    chk("drop_once", 32'(drop), 0);
    wait_result(lat);
    chk("drop_latency", 32'(lat + 3), 5);
    chk_result("drop_first", 1, 50, 20, 1);
    send(pack(0, 0, 0, 7), 0, 0);            // accepted in result_valid cycle
    chk("b2b_rv_low", 32'(result_valid), 0);
    chk("b2b_hold_class", 32'(class_out), 1);
    chk("b2b_busy", 32'(ready), 0);
    wait_result(lat);
    chk("b2b_latency", 32'(lat), 5);
    chk_result("b2b", 3, 7, 7, 1);
    tick();
    $display("[TB] drop/b2b: class=%0d score=%0d", class_out, score_out);

    // Reset mid-scan
    send(pack(10, 50, 30, 20), 40, 15);
    tick();
    tick();                                   // two elements processed
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 32'(ready), 1);
    chk("mrst_rv", 32'(result_valid), 0);
    chk_result("mrst", 0, 0, 0, 0);
    chk("mrst_drop", 32'(drop), 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (result_valid) seen++;
    end
    chk("mrst_no_result", 32'(seen), 0);
    send(pack(5, 3, 9, 1), 9, 4);
    wait_result(lat);
    chk("post_rst_latency", 32'(lat), 5);
    chk_result("post_rst", 2, 9, 4, 1);
    tick();
    $display("[TB] post-reset: class=%0d score=%0d margin=%0d detect=%0d", class_out, score_out, margin_out, detect);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
